// File: rtl/host_reg_file.sv
// Host-visible register file with a doorbell-driven command FIFO.
// Ports:
//   clk, rst        - clock and asynchronous active-high reset
//   reg_in[63:0]    - write data; low half feeds even registers, high half odd
//   reg_wr[255:0]   - byte enables, bit 4*a+b writes byte b of register a
//   reg_out[2047:0] - registered readback, register a at [32*a +: 32]
//   status_in[511:0]- user status words, word k reads back as register 48+k
//   cmd_data[63:0]  - FIFO head {operand_hi, operand_lo}, 0 when empty
//   cmd_valid       - FIFO non-empty
//   cmd_ready       - user accepts the head entry
module host_reg_file #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   reg_in,
    input  logic [255:0]  reg_wr,
    output logic [2047:0] reg_out,
    input  logic [511:0]  status_in,
    output logic [63:0]   cmd_data,
    output logic          cmd_valid,
    input  logic          cmd_ready
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [63:0]   mem_q   [FIFO_DEPTH];
    logic [63:0]   mem_nxt [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q, rd_nxt, wr_nxt;
    logic [CW-1:0] count_q, count_nxt;
    logic          ovf_q, ovf_nxt;
    logic [2047:0] reg_nxt;
    logic [63:0]   cmd_data_nxt;
    logic          push, pop, push_ok, ovf_clr, empty_nxt, full_nxt;

    // Enables that map to read-only or unimplemented bytes.
    logic unused;
    assign unused = ^{reg_wr[255:192], reg_wr[15], reg_wr[13:12]};

    // Next-state for the register image, the FIFO and the overflow flag.
    always_comb begin
        reg_nxt = reg_out;
        for (int a = 0; a < 48; a++) begin
            if (a != 2 && a != 3) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_wr[4*a+b]) begin
                        reg_nxt[32*a+8*b +: 8] = reg_in[32*(a%2)+8*b +: 8];
                    end
                end
            end
        end

        pop     = cmd_valid & cmd_ready;
        push    = |reg_wr[11:8];
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push_ok = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
        ovf_clr = reg_wr[14] & reg_in[48];

        mem_nxt   = mem_q;
        rd_nxt    = rd_q;
        wr_nxt    = wr_q;
        count_nxt = count_q;
        if (push_ok) begin
            // Entry uses next-state operands so same-cycle writes are captured.
            mem_nxt[wr_q] = reg_nxt[63:0];
            wr_nxt        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_nxt = rd_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_nxt = count_q + CW'(1);
            2'b01:   count_nxt = count_q - CW'(1);
            default: count_nxt = count_q;
        endcase

        // Set wins over clear.
        ovf_nxt = ovf_q;
        if (ovf_clr) ovf_nxt = 1'b0;
        if (push && !push_ok) ovf_nxt = 1'b1;

        empty_nxt = (count_nxt == '0);
        full_nxt  = (count_nxt == CW'(FIFO_DEPTH));

        reg_nxt[95:64]     = 32'h0;
        reg_nxt[127:96]    = {15'h0, ovf_nxt, 6'h0, empty_nxt, full_nxt, 3'h0, 5'(count_nxt)};
        reg_nxt[2047:1536] = status_in;

        cmd_data_nxt = empty_nxt ? 64'h0 : mem_nxt[rd_nxt];
    end

    // State registers; cmd_data/cmd_valid track the post-edge FIFO head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_out   <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cmd_data  <= '0;
            cmd_valid <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            reg_out   <= reg_nxt;
            rd_q      <= rd_nxt;
            wr_q      <= wr_nxt;
            count_q   <= count_nxt;
            ovf_q     <= ovf_nxt;
            cmd_data  <= cmd_data_nxt;
            cmd_valid <= !empty_nxt;
            mem_q     <= mem_nxt;
        end
    end

endmodule
